// File: rtl/y86_pkg.sv
// Y86-64 fetch definitions: instruction codes, encoded lengths and fetch FSM states.
package y86_pkg;

  localparam logic [3:0] I_HALT   = 4'h0;
  localparam logic [3:0] I_NOP    = 4'h1;
  localparam logic [3:0] I_CMOVXX = 4'h2;
  localparam logic [3:0] I_IRMOVQ = 4'h3;
  localparam logic [3:0] I_RMMOVQ = 4'h4;
  localparam logic [3:0] I_MRMOVQ = 4'h5;
  localparam logic [3:0] I_OPQ    = 4'h6;
  localparam logic [3:0] I_JXX    = 4'h7;
  localparam logic [3:0] I_CALL   = 4'h8;
  localparam logic [3:0] I_RET    = 4'h9;
  localparam logic [3:0] I_PUSHQ  = 4'hA;
  localparam logic [3:0] I_POPQ   = 4'hB;

  localparam logic [3:0] LEN_1  = 4'd1;
  localparam logic [3:0] LEN_2  = 4'd2;
  localparam logic [3:0] LEN_9  = 4'd9;
  localparam logic [3:0] LEN_10 = 4'd10;

  typedef enum logic [1:0] {
    IDLE,
    FETCH,
    DONE,
    STOP
  } fetch_state_t;

endpackage

// File: rtl/instr_len.sv
// Maps an instruction code to its encoded length and which optional fields it carries.
module instr_len
  import y86_pkg::*;
(
  input  logic [3:0] icode,
  output logic [3:0] len,
  output logic       need_regids,
  output logic       need_valc
);

  always_comb begin
    len         = LEN_1;
    need_regids = 1'b0;
    need_valc   = 1'b0;
    case (icode)
      I_CMOVXX, I_OPQ, I_PUSHQ, I_POPQ: begin
        len         = LEN_2;
        need_regids = 1'b1;
      end
      I_JXX, I_CALL: begin
        len       = LEN_9;
        need_valc = 1'b1;
      end
      I_IRMOVQ, I_RMMOVQ, I_MRMOVQ: begin
        len         = LEN_10;
        need_regids = 1'b1;
        need_valc   = 1'b1;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/pc_fetch.sv
// Y86-64 byte-serial instruction fetch and decode.
// Optional FETCH_BOUNDS_CHECK_EN: refuse addresses at or above IMEM_BYTES and raise imem_error.
module pc_fetch
  import y86_pkg::*;
#(
  parameter logic [63:0] RESET_PC   = 64'd2,
  parameter int unsigned IMEM_BYTES = 1024
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [63:0] pc_in,
  input  logic        pc_load,
  output logic        imem_req,
  output logic [63:0] imem_addr,
  input  logic        imem_ack,
  input  logic [7:0]  imem_rdata,
  output logic [3:0]  icode,
  output logic [3:0]  ifun,
  output logic [3:0]  rA,
  output logic [3:0]  rB,
  output logic [63:0] valC,
  output logic [63:0] valP,
  output logic [63:0] pc_out,
  output logic        instr_valid,
  output logic        instr_invalid,
  output logic        imem_error,
  output logic        halt
);

  if (IMEM_BYTES == 0) begin : g_bad_imem
    $error("pc_fetch: IMEM_BYTES must be nonzero");
  end

  fetch_state_t state, state_nxt;
  logic [3:0]  cnt;
  logic [63:0] fetch_addr;
  logic [3:0]  dec_icode;
  logic [3:0]  len;
  logic        need_regids;
  logic        need_valc;
  logic        dec_invalid;
  logic        last;
  logic        take;
  logic        accept_load;
  logic        addr_oob;

  assign fetch_addr  = pc_out + 64'(cnt);
  // Byte 0 decodes from the live bus; later bytes use the latched icode.
  assign dec_icode   = (cnt == 4'd0) ? imem_rdata[7:4] : icode;
  assign dec_invalid = (dec_icode > I_POPQ);
  assign last        = (cnt == len - 4'd1);
  assign accept_load = pc_load && (state == IDLE || state == DONE);

`ifdef FETCH_BOUNDS_CHECK_EN
  assign addr_oob = (fetch_addr >= 64'(IMEM_BYTES));
`else
  assign addr_oob   = 1'b0;
  assign imem_error = 1'b0;
`endif

  instr_len u_len (
    .icode       (dec_icode),
    .len         (len),
    .need_regids (need_regids),
    .need_valc   (need_valc)
  );

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    imem_req  = 1'b0;
    imem_addr = '0;
    take      = 1'b0;
    case (state)
      IDLE, DONE: if (pc_load) state_nxt = FETCH;
      FETCH: begin
        if (addr_oob) begin
          state_nxt = STOP;
        end else begin
          imem_req  = 1'b1;
          imem_addr = fetch_addr;
          if (imem_ack) begin
            take = 1'b1;
            if (last) state_nxt = (dec_invalid || dec_icode == I_HALT) ? STOP : DONE;
          end
        end
      end
      STOP: ;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pc_out        <= RESET_PC;
      cnt           <= '0;
      icode         <= '0;
      ifun          <= '0;
      rA            <= '0;
      rB            <= '0;
      valC          <= '0;
      valP          <= '0;
      instr_valid   <= 1'b0;
      instr_invalid <= 1'b0;
      halt          <= 1'b0;
    end else begin
      if (accept_load) begin
        pc_out      <= pc_in;
        cnt         <= '0;
        instr_valid <= 1'b0;
        icode       <= '0;
        ifun        <= '0;
        rA          <= '1;
        rB          <= '1;
        valC        <= '0;
        valP        <= '0;
      end
      if (take) begin
        cnt <= cnt + 4'd1;
        if (cnt == 4'd0)
          {icode, ifun} <= imem_rdata;
        else if (need_regids && cnt == 4'd1)
          {rA, rB} <= imem_rdata;
        // Shifting in from the top leaves the first constant byte in valC[7:0].
        else if (need_valc)
          valC <= {imem_rdata, valC[63:8]};
        if (last) begin
          valP          <= pc_out + 64'(len);
          instr_valid   <= !dec_invalid;
          instr_invalid <= dec_invalid;
          halt          <= (dec_icode == I_HALT);
        end
      end
    end
  end

`ifdef FETCH_BOUNDS_CHECK_EN
  always_ff @(posedge clk) begin
    if (rst)                            imem_error <= 1'b0;
    else if (state == FETCH && addr_oob) imem_error <= 1'b1;
  end
`endif

endmodule

// File: tb/tb_pc_fetch.sv
// Directed self-checking bench for pc_fetch with a byte memory model of selectable ack delay.
module tb_pc_fetch;

  logic        clk = 1'b0;
  logic        rst;
  logic [63:0] pc_in;
  logic        pc_load;
  logic        imem_req;
  logic [63:0] imem_addr;
  logic        imem_ack;
  logic [7:0]  imem_rdata;
  logic [3:0]  icode, ifun, rA, rB;
  logic [63:0] valC, valP, pc_out;
  logic        instr_valid, instr_invalid, imem_error, halt;

  always #5 clk = ~clk;

  logic [7:0]  mem [0:1023];
  int unsigned wait_n;
  int unsigned wcnt;
  logic        stray;

  always @(posedge clk) begin
    if (rst || !imem_req || imem_ack) wcnt <= 0;
    else                              wcnt <= wcnt + 1;
  end

  assign imem_ack   = (imem_req && wcnt >= wait_n) || stray;
  assign imem_rdata = mem[imem_addr[9:0]];

  pc_fetch #(.RESET_PC(64'd2), .IMEM_BYTES(1024)) dut (
    .clk           (clk),
    .rst           (rst),
    .pc_in         (pc_in),
    .pc_load       (pc_load),
    .imem_req      (imem_req),
    .imem_addr     (imem_addr),
    .imem_ack      (imem_ack),
    .imem_rdata    (imem_rdata),
    .icode         (icode),
    .ifun          (ifun),
    .rA            (rA),
    .rB            (rB),
    .valC          (valC),
    .valP          (valP),
    .pc_out        (pc_out),
    .instr_valid   (instr_valid),
    .instr_invalid (instr_invalid),
    .imem_error    (imem_error),
    .halt          (halt)
  );

  int passed = 0;
  int failed = 0;
  int total  = 0;
  int cyc;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      failed++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // v holds bytes in memory order, leftmost byte first.
  task automatic put_seq(input int unsigned a, input int unsigned n, input logic [79:0] v);
    for (int unsigned i = 0; i < n; i++) mem[(a + i) % 1024] = v[79 - 8*i -: 8];
  endtask

  // Called at a negedge; returns at the negedge following the accepting edge.
  task automatic load(input logic [63:0] pc);
    pc_in   = pc;
    pc_load = 1'b1;
    @(negedge clk);
    pc_load = 1'b0;
  endtask

  task automatic wait_done(input int start, input int bound, output int c);
    c = start;
    while (!(instr_valid || instr_invalid || halt || imem_error) && c < bound) begin
      @(negedge clk);
      c++;
    end
    chk("done_within_bound", {63'b0, instr_valid || instr_invalid || halt || imem_error}, 64'd1);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    for (int i = 0; i < 1024; i++) mem[i] = 8'h00;
    rst = 1'b1; pc_load = 1'b0; pc_in = '0; stray = 1'b0; wait_n = 0;
    repeat (2) @(negedge clk);

    chk("rst_pc_out", pc_out, 64'd2);
    chk("rst_req", {63'b0, imem_req}, 64'd0);
    chk("rst_addr", imem_addr, 64'd0);
    chk("rst_fields", {icode, ifun, rA, rB}, 64'd0);
    chk("rst_valC", valC, 64'd0);
    chk("rst_valP", valP, 64'd0);
    chk("rst_status", {60'b0, instr_valid, instr_invalid, imem_error, halt}, 64'd0);
    rst = 1'b0;

    // irmovq $10, %rbx at 2
    put_seq(2, 10, 80'h30F30A00000000000000);
    load(64'd2);
    chk("irm_req", {63'b0, imem_req}, 64'd1);
    chk("irm_addr0", imem_addr, 64'd2);
    wait_done(1, 60, cyc);
    chk("irm_latency", cyc, 64'd11);
    chk("irm_icode_ifun", {icode, ifun}, 64'h30);
    chk("irm_rA_rB", {rA, rB}, 64'hF3);
    chk("irm_valC", valC, 64'd10);
    chk("irm_valP", valP, 64'd12);
    chk("irm_pc_out", pc_out, 64'd2);

    // call 0x100 at 0x40, loaded from DONE
    put_seq(64, 9, 80'h80000100000000000000);
    load(64'h40);
    wait_done(1, 60, cyc);
    chk("call_latency", cyc, 64'd10);
    chk("call_icode", icode, 64'h8);
    chk("call_rA_rB", {rA, rB}, 64'hFF);
    chk("call_valC", valC, 64'h100);
    chk("call_valP", valP, 64'h49);

    // addq %rdx, %rbx at 0x60
    put_seq(96, 2, 80'h60230000000000000000);
    load(64'h60);
    wait_done(1, 60, cyc);
    chk("opq_latency", cyc, 64'd3);
    chk("opq_fields", {icode, ifun, rA, rB}, 64'h6023);
    chk("opq_valC", valC, 64'd0);
    chk("opq_valP", valP, 64'h62);

    // rmmovq with 3-cycle ack delay and an ignored mid-fetch pc_load
    wait_n = 3;
    put_seq(128, 10, 80'h40120102030405060708);
    load(64'h80);
    chk("slow_req_c1", {63'b0, imem_req}, 64'd1);
    chk("slow_addr_c1", imem_addr, 64'h80);
    @(negedge clk);
    chk("slow_addr_c2", imem_addr, 64'h80);
    pc_in = 64'h200; pc_load = 1'b1;
    @(negedge clk);
    pc_load = 1'b0;
    chk("slow_req_c3", {63'b0, imem_req}, 64'd1);
    chk("slow_addr_c3", imem_addr, 64'h80);
    @(negedge clk);
    chk("slow_addr_c4", imem_addr, 64'h80);
    @(negedge clk);
    chk("slow_addr_c5", imem_addr, 64'h81);
    wait_done(5, 100, cyc);
    chk("slow_latency", cyc, 64'd41);
    chk("slow_fields", {icode, ifun, rA, rB}, 64'h4012);
    chk("slow_valC", valC, 64'h0807060504030201);
    chk("slow_valP", valP, 64'h8A);
    chk("slow_pc_out", pc_out, 64'h80);
    wait_n = 0;

    // reset at byte 4 of a 10-byte fetch, together with pc_load
    put_seq(256, 10, 80'h30F41122334455667788);
    load(64'h100);
    repeat (4) @(negedge clk);
    chk("abort_addr_b4", imem_addr, 64'h104);
    rst = 1'b1; pc_load = 1'b1; pc_in = 64'h300;
    @(negedge clk);
    rst = 1'b0; pc_load = 1'b0;
    chk("abort_pc_out", pc_out, 64'd2);
    chk("abort_req", {63'b0, imem_req}, 64'd0);
    chk("abort_addr", imem_addr, 64'd0);
    chk("abort_valid", {63'b0, instr_valid}, 64'd0);
    stray = 1'b1;
    @(negedge clk);
    stray = 1'b0;
    chk("stray_req", {63'b0, imem_req}, 64'd0);
    chk("stray_pc_out", pc_out, 64'd2);
    chk("stray_icode", icode, 64'd0);

    // halt at 0x20, then STOP ignores pc_load
    mem[32] = 8'h00;
    load(64'h20);
    wait_done(1, 60, cyc);
    chk("halt_latency", cyc, 64'd2);
    chk("halt_status", {62'b0, instr_valid, halt}, 64'd3);
    chk("halt_valP", valP, 64'h21);
    load(64'h40);
    chk("stop_req_c1", {63'b0, imem_req}, 64'd0);
    @(negedge clk);
    chk("stop_req_c2", {63'b0, imem_req}, 64'd0);
    chk("stop_pc_out", pc_out, 64'h20);
    do_reset();

    // invalid icode 0xD at 0x10
    mem[16] = 8'hD0;
    load(64'h10);
    wait_done(1, 60, cyc);
    chk("inv_latency", cyc, 64'd2);
    chk("inv_status", {62'b0, instr_invalid, instr_valid}, 64'd2);
    chk("inv_valP", valP, 64'h11);
    chk("inv_icode", icode, 64'hD);
    load(64'h40);
    chk("inv_stop_req_c1", {63'b0, imem_req}, 64'd0);
    @(negedge clk);
    chk("inv_stop_req_c2", {63'b0, imem_req}, 64'd0);
    chk("inv_stop_pc_out", pc_out, 64'h10);
    do_reset();

`ifndef FETCH_BOUNDS_CHECK_EN
    // ret at the top of the address space: valP wraps to zero
    mem[1023] = 8'h90;
    load(64'hFFFF_FFFF_FFFF_FFFF);
    chk("wrap_addr", imem_addr, 64'hFFFF_FFFF_FFFF_FFFF);
    wait_done(1, 60, cyc);
    chk("wrap_latency", cyc, 64'd2);
    chk("wrap_fields", {icode, ifun, rA, rB}, 64'h90FF);
    chk("wrap_valP", valP, 64'd0);
    chk("no_bounds_error", {63'b0, imem_error}, 64'd0);
`else
    // 10-byte instruction starting at the last memory byte
    mem[1023] = 8'h30;
    load(64'd1023);
    chk("oob_req_c1", {63'b0, imem_req}, 64'd1);
    chk("oob_addr_c1", imem_addr, 64'd1023);
    @(negedge clk);
    chk("oob_no_req", {63'b0, imem_req}, 64'd0);
    @(negedge clk);
    chk("oob_error", {63'b0, imem_error}, 64'd1);
    chk("oob_stop_req", {63'b0, imem_req}, 64'd0);
`endif

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/pc_fetch.md
PC_FETCH -- requirements
Module: pc_fetch

Interface
REQ-001 The block SHALL have parameter RESET_PC, default 64'd2: PC loaded on reset.
REQ-002 The block SHALL have parameter IMEM_BYTES, default 1024: instruction memory size in bytes.
REQ-003 The block SHALL have port clk, input, 1 bit: single clock; all state changes on its rising edge.
REQ-004 The block SHALL have port rst, input, 1 bit: synchronous, active-high reset.
REQ-005 The block SHALL have port pc_in, input, 64 bits: next PC from the PC-update stage (updatedPC).
REQ-006 The block SHALL have port pc_load, input, 1 bit: one-cycle request to fetch at pc_in.
REQ-007 The block SHALL have port imem_req, output, 1 bit: byte read request.
REQ-008 The block SHALL have port imem_addr, output, 64 bits: byte address of the request.
REQ-009 The block SHALL have port imem_ack, input, 1 bit: read data valid.
REQ-010 The block SHALL have port imem_rdata, input, 8 bits: read data byte.
REQ-011 The block SHALL have outputs icode[3:0], ifun[3:0], rA[3:0], rB[3:0], valC[63:0] and valP[63:0]: decoded fields.
REQ-012 The block SHALL have output pc_out, 64 bits: PC of the current instruction.
REQ-013 The block SHALL have outputs instr_valid, instr_invalid, imem_error and halt, 1 bit each: status.

Function
REQ-014 The FSM SHALL have states IDLE, FETCH, DONE and STOP.
REQ-015 When pc_load=1 in IDLE or DONE, the block SHALL latch pc_in into pc_out, clear byte count, clear instr_valid and enter FETCH next cycle.
REQ-016 pc_load SHALL be ignored in FETCH and STOP.
REQ-017 In FETCH, the block SHALL hold imem_req=1 with imem_addr=pc_out+byte_count stable until imem_ack=1 is sampled; each sampled ack consumes exactly one byte.
REQ-018 imem_ack received while imem_req=0 SHALL be ignored.
REQ-019 Byte 0 SHALL give icode=[7:4] and ifun=[3:0], which set the instruction length.
REQ-020 Lengths SHALL be: halt/nop/ret=1; cmovXX/OPq/pushq/popq=2; jXX/call=9; irmovq/rmmovq/mrmovq=10.
REQ-021 For 2- and 10-byte instructions, byte 1 SHALL give rA=[7:4] and rB=[3:0]; otherwise rA and rB SHALL be 4'hF.
REQ-022 valC SHALL be assembled little-endian from the last 8 bytes (bytes 1-8 for jXX/call, 2-9 for 10-byte forms); otherwise valC=0.
REQ-023 valP SHALL equal pc_out+length modulo 2^64, with wrap-around allowed.
REQ-024 The cycle after the final ack, the block SHALL enter DONE with instr_valid=1; all fields stay stable until the next accepted pc_load.
REQ-025 An icode above 4'hB SHALL complete as 1 byte with instr_invalid=1 and valP=pc_out+1, then enter STOP.
REQ-026 icode=0 (halt) SHALL give instr_valid=1 and halt=1, then enter STOP.
REQ-027 STOP SHALL be exited only by rst; imem_req=0 in STOP.
REQ-028 Fetch latency SHALL be at least length+1 cycles from pc_load to instr_valid, with zero-wait memory.

Reset
REQ-029 On rst, the block SHALL set pc_out=RESET_PC, state=IDLE, imem_req=0, imem_addr=0, all decoded fields=0, all status outputs=0.
REQ-030 rst during FETCH SHALL abort the transfer; a late imem_ack after reset SHALL be ignored.
REQ-031 rst SHALL take priority over pc_load in the same cycle.

Configuration
REQ-032 With FETCH_BOUNDS_CHECK_EN defined, any byte address at or above IMEM_BYTES SHALL NOT be requested; instead imem_error=1 and the block enters STOP the next cycle.
REQ-033 Without FETCH_BOUNDS_CHECK_EN, no address check SHALL exist and imem_error SHALL be tied to 0.

Structure
REQ-034 Package y86_pkg SHALL hold the icode constants (HALT..POPQ), the instruction-length constants and the FSM state enum.
REQ-035 The combinational sub-module instr_len SHALL map icode to length, needs-regids and needs-valC.

Verification
REQ-036 After reset, pc_load with pc_in=2 and bytes 30 F3 0A 00.. (10 total): icode=3, rA=F, rB=3, valC=10, valP=12, instr_valid after 11 cycles.
REQ-037 pc_load with pc_in=0x40 and bytes 80 00 01 00 00 00 00 00 00: valC=0x100, valP=0x49, rA=rB=F.
REQ-038 Byte 0xD0 at pc 0x10: instr_invalid=1, valP=0x11, STOP; a following pc_load produces no imem_req.
REQ-039 imem_ack delayed 3 cycles per byte: imem_addr and imem_req stay stable while waiting; fields are correct; a pc_load asserted mid-fetch is ignored.
REQ-040 rst asserted at byte 4 of a 10-byte fetch: next cycle pc_out=2, imem_req=0, IDLE; a stray ack is ignored.
REQ-041 With FETCH_BOUNDS_CHECK_EN and pc_in=IMEM_BYTES-1 on a 10-byte instruction: imem_error=1 at byte 1 and no request for address IMEM_BYTES.
